word_shift_out: RTL and testbench
=================================

// Module: word_shift_out
//
// PURPOSE
//   Parallel-to-serial reader for a WIDTH-bit register word.
//   Captures a word on load, then presents it one bit per enabled cycle on out, MSB first.
//   valid qualifies each bit; last flags the final one.
//   Counterpart to the Bit/Register storage chain: Bit/Register write a bit in; this block reads a word out serially.
//   Feeds serial sinks such as UART TX and LED/shift-register drivers.
//
// PARAMETERS
//   WIDTH  16  word length in bits (>=1); the bit counter is $clog2(WIDTH) bits, minimum 1
//
// PORTS
//   clk     in   1      system clock, all state changes on posedge
//   reset   in   1      asynchronous, active-high; clears all state immediately
//   in      in   WIDTH  parallel word, sampled only on an accepted load
//   load    in   1      capture request; accepted when load=1 && ready=1 at posedge clk
//   en      in   1      advance strobe; the current bit is consumed at posedge when en=1
//   ready   out  1      1 = IDLE, a load will be accepted
//   out     out  1      current serial bit (MSB first); 0 when valid=0
//   valid   out  1      out holds a word bit
//   last    out  1      valid=1 and out is bit 0 of the word
//
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, shreg=0, cnt=0.
//     Outputs drop immediately: ready=1, valid=0, last=0, out=0.
//     Reset mid-word aborts the word; the remaining bits are discarded.
//   State machine: IDLE, SHIFT. All outputs are registered or decoded from registered state; no in->out comb path.
//   IDLE:
//     load=1 at posedge -> shreg<=in, cnt<=0, state<=SHIFT.
//     load=0 -> hold. en is ignored.
//   SHIFT:
//     Outputs: valid=1, out=shreg[WIDTH-1], last=(cnt==WIDTH-1).
//     en=0 -> hold. out, valid and last stay stable, so a bit may be held indefinitely.
//     en=1 && cnt<WIDTH-1 -> shreg<=shreg<<1, cnt<=cnt+1.
//     en=1 && cnt==WIDTH-1 -> state<=IDLE, shreg<=0.
//   Latency: the first bit is valid in the cycle after the accepted load.
//     With en held at 1, a word occupies exactly WIDTH cycles, and ready returns on cycle WIDTH+1.
//   No back-to-back words: ready=0 throughout SHIFT.
//     load during SHIFT is ignored; it is not queued, and in is not sampled.
//     The minimum word-to-word spacing is WIDTH+1 cycles.
//   Load and en in the same IDLE cycle: the load is taken and en has no effect.
//     The first bit still appears in the next cycle.
//   WIDTH=1: a single SHIFT cycle, with last=1 on that cycle.
//   in may change freely after the load edge; shreg holds the captured copy.
//
// TESTING (WIDTH=16 unless noted; cycle 0 = load edge)
//   1. Basic word, en=1 always:
//      load in=16'hA5C3 -> out over cycles 1..16 = 1010_0101_1100_0011.
//      valid=1 on cycles 1..16; last=1 only on cycle 16; ready=1 on cycle 17.
//   2. en gating, word 16'h8001:
//      en=0 on cycles 2..5 -> out stays 0 with valid=1 and last=0 during the stall.
//      Total word length is 20 cycles; the final bit (1) carries last=1.
//   3. Load while busy:
//      load 16'hFFFF, then load 16'h0000 on cycle 3 -> all 16 bits are 1; the second load is ignored.
//      A load on cycle 17 (ready=1) is accepted.
//   4. Async reset mid-word:
//      load 16'h1234, assert reset between edges 6 and 7 -> ready=1, valid=0, out=0 before the next posedge.
//      After release, a load of 16'h00FF serialises cleanly.
//   5. Idle quiet: load=0 and random en for 50 cycles -> valid=0, out=0, last=0, ready=1 throughout.
//   6. WIDTH=1: load in=1 -> cycle 1 has out=1, valid=1, last=1; cycle 2 has ready=1.
//      Repeat with in=0 -> out=0, valid=1.
//   Bench: random load/en/in for 1000 cycles against a behavioural model; report FAIL with cycle and signal values.

Source files
------------

// File: rtl/word_shift_out.sv
// Parallel-to-serial word reader: captures WIDTH bits on an accepted load and
// presents them MSB first, one bit per enabled cycle, with valid/last qualifiers.
module word_shift_out #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             en,
  output logic             ready,
  output logic             out,
  output logic             valid,
  output logic             last
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // en is deliberately ignored here; a load always wins.
        if (load) begin
          shreg_d = in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (en) begin
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
          end else begin
            shreg_d = shreg_q << 1;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // All outputs decode registered state only, so in/load never reach them combinationally.
  assign ready = (state_q == IDLE);
  assign valid = (state_q == SHIFT);
  assign out   = valid & shreg_q[WIDTH-1];
  assign last  = valid & (cnt_q == CNT_LAST);

endmodule

// File: tb/tb_word_shift_out.sv
// Directed and randomised checks of word_shift_out at WIDTH=16, plus a WIDTH=1 instance.
module tb_word_shift_out;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din;
  logic         load, en;
  logic         ready, out, valid, last;

  logic         din1, load1, en1;
  logic         ready1, out1, valid1, last1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  word_shift_out #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in(din), .load(load), .en(en),
    .ready(ready), .out(out), .valid(valid), .last(last)
  );

  word_shift_out #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .in(din1), .load(load1), .en(en1),
    .ready(ready1), .out(out1), .valid(valid1), .last(last1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the 16 bits of an already-loaded word (en=1), then ready on cycle 17.
  task automatic drain_word(input string name, input logic [W-1:0] w);
    logic [3:0] exp;
    en = 1'b1;
    for (int k = 1; k <= W; k++) begin
      exp = {1'b0, 1'b1, w[W-k], (k == W)};
      tests++;
      if ({ready, valid, out, last} !== exp) begin
        fails++;
        $display("FAIL %s cycle %0d: {ready,valid,out,last}=%b required %b", name, k, {ready, valid, out, last}, exp);
      end
      tick();
    end
    tests++;
    if ({ready, valid, out, last} !== 4'b1000) begin
      fails++;
      $display("FAIL %s cycle %0d idle: {ready,valid,out,last}=%b required 1000", name, W + 1, {ready, valid, out, last});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; en = 1'b0; din = '0;
    load1 = 1'b0; en1 = 1'b0; din1 = 1'b0;
    #1;
    tests++;
    if ({ready, valid, out, last} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_state: {ready,valid,out,last}=%b required 1000", {ready, valid, out, last});
    end
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    din = 16'hA5C3; load = 1'b1; en = 1'b1;
    tick();
    load = 1'b0; din = 16'h0000;
    drain_word("basic_A5C3", 16'hA5C3);
  endtask

  task automatic test_en_gating();
    int idx;
    logic [3:0] exp;
    din = 16'h8001; load = 1'b1; en = 1'b1;
    tick();
    load = 1'b0;
    idx = W - 1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      en = !(cyc >= 2 && cyc <= 5);
      exp = {1'b0, 1'b1, din[idx], (idx == 0)};
      tests++;
      if ({ready, valid, out, last} !== exp) begin
        fails++;
        $display("FAIL en_gating cycle %0d: {ready,valid,out,last}=%b required %b", cyc, {ready, valid, out, last}, exp);
      end
      tick();
      if (en) idx--;
    end
    tests++;
    if ({ready, valid, out, last} !== 4'b1000) begin
      fails++;
      $display("FAIL en_gating cycle 21: {ready,valid,out,last}=%b required 1000", {ready, valid, out, last});
    end
    en = 1'b1;
  endtask

  task automatic test_load_while_busy();
    logic [3:0] exp;
    din = 16'hFFFF; load = 1'b1; en = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 1; k <= W; k++) begin
      if (k == 3) begin load = 1'b1; din = 16'h0000; end
      else        begin load = 1'b0; end
      exp = {1'b0, 1'b1, 1'b1, (k == W)};
      tests++;
      if ({ready, valid, out, last} !== exp) begin
        fails++;
        $display("FAIL busy_load cycle %0d: {ready,valid,out,last}=%b required %b", k, {ready, valid, out, last}, exp);
      end
      tick();
    end
    tests++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL busy_load cycle 17 ready: %b required 1", ready);
    end
    din = 16'h00FF; load = 1'b1;
    tick();
    load = 1'b0;
    drain_word("busy_reload_00FF", 16'h00FF);
  endtask

  task automatic test_async_reset();
    din = 16'h1234; load = 1'b1; en = 1'b1;
    tick();
    load = 1'b0;
    repeat (6) tick();
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if ({ready, valid, out, last} !== 4'b1000) begin
      fails++;
      $display("FAIL async_reset mid-word: {ready,valid,out,last}=%b required 1000", {ready, valid, out, last});
    end
    tick();
    reset = 1'b0;
    tick();
    tests++;
    if ({ready, valid, out, last} !== 4'b1000) begin
      fails++;
      $display("FAIL async_reset after release: {ready,valid,out,last}=%b required 1000", {ready, valid, out, last});
    end
    din = 16'h00FF; load = 1'b1;
    tick();
    load = 1'b0;
    drain_word("after_reset_00FF", 16'h00FF);
  endtask

  task automatic test_idle_quiet();
    load = 1'b0;
    for (int i = 0; i < 50; i++) begin
      en = 1'($urandom_range(0, 1));
      din = 16'($urandom);
      tick();
      tests++;
      if ({ready, valid, out, last} !== 4'b1000) begin
        fails++;
        $display("FAIL idle_quiet cycle %0d: {ready,valid,out,last}=%b required 1000", i, {ready, valid, out, last});
      end
    end
  endtask

  task automatic test_width1();
    for (int v = 1; v >= 0; v--) begin
      din1 = 1'(v); load1 = 1'b1; en1 = 1'b1;
      tick();
      load1 = 1'b0;
      tests++;
      if ({ready1, valid1, out1, last1} !== {1'b0, 1'b1, 1'(v), 1'b1}) begin
        fails++;
        $display("FAIL width1 in=%0d cycle 1: {ready,valid,out,last}=%b required %b", v, {ready1, valid1, out1, last1}, {1'b0, 1'b1, 1'(v), 1'b1});
      end
      tick();
      tests++;
      if ({ready1, valid1, out1, last1} !== 4'b1000) begin
        fails++;
        $display("FAIL width1 in=%0d cycle 2: {ready,valid,out,last}=%b required 1000", v, {ready1, valid1, out1, last1});
      end
    end
  endtask

  task automatic test_random();
    logic         m_busy = 1'b0;
    logic [W-1:0] m_sh   = '0;
    int           m_cnt  = 0;
    logic [3:0]   exp;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      exp = {!m_busy, m_busy, m_busy & m_sh[W-1], m_busy && (m_cnt == W - 1)};
      tests++;
      if ({ready, valid, out, last} !== exp) begin
        fails++;
        $display("FAIL random cycle %0d: {ready,valid,out,last}=%b required %b", cyc, {ready, valid, out, last}, exp);
      end
      load = ($urandom_range(0, 3) == 0);
      en   = ($urandom_range(0, 3) != 0);
      din  = 16'($urandom);
      if (!m_busy) begin
        if (load) begin m_sh = din; m_cnt = 0; m_busy = 1'b1; end
      end else if (en) begin
        if (m_cnt == W - 1) begin m_busy = 1'b0; m_sh = '0; end
        else begin m_sh = m_sh << 1; m_cnt++; end
      end
      tick();
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_en_gating();
    test_load_while_busy();
    test_async_reset();
    test_idle_quiet();
    test_width1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
